// File: rtl/turf_event_pkg.sv
// Shared state encoding, buffer IDs and helpers for the TURF trigger path.
package turf_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIGITIZE = 2'd1,
        ST_HOLDOFF  = 2'd2,
        ST_DEAD     = 2'd3
    } bufmgr_state_t;

    localparam logic [1:0] BUF_A = 2'd0;
    localparam logic [1:0] BUF_B = 2'd1;
    localparam logic [1:0] BUF_C = 2'd2;
    localparam logic [1:0] BUF_D = 2'd3;

    localparam int MIN_HOLDOFF = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [3:0] pair_mask(input logic p);
        return p ? ((4'b0001 << BUF_C) | (4'b0001 << BUF_D))
                 : ((4'b0001 << BUF_A) | (4'b0001 << BUF_B));
    endfunction

    function automatic logic mask_free(input logic [3:0] h, input logic dbl);
        return dbl ? ((h[1:0] == 2'b00) || (h[3:2] == 2'b00))
                   : (h != 4'hF);
    endfunction

endpackage

// File: rtl/turf_buf_allocator.sv
// Combinational round-robin allocator for single buffers or A/B, C/D pairs.
module turf_buf_allocator
    import turf_event_pkg::*;
(
    input  logic       i_double,
    input  logic [3:0] i_hold,
    input  logic [1:0] i_rr,
    output logic       o_free,
    output logic [1:0] o_id,
    output logic [3:0] o_mask,
    output logic [1:0] o_rr
);

    logic [1:0] w_idx;
    logic       w_pair;

    always_comb begin
        o_free = 1'b0;
        o_id   = 2'd0;
        o_mask = i_hold;
        o_rr   = i_rr;
        w_idx  = 2'd0;
        w_pair = 1'b0;
        if (i_double) begin
            for (int k = 0; k < 2; k++) begin
                w_pair = i_rr[0] ^ 1'(k);
                if (!o_free && ((i_hold & pair_mask(w_pair)) == 4'd0)) begin
                    o_free = 1'b1;
                    o_id   = {1'b0, w_pair};
                    o_mask = i_hold | pair_mask(w_pair);
                    o_rr   = {i_rr[1], ~w_pair};
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                w_idx = i_rr + 2'(k);
                if (!o_free && !i_hold[w_idx]) begin
                    o_free = 1'b1;
                    o_id   = w_idx;
                    o_mask = i_hold | (4'b0001 << w_idx);
                    o_rr   = w_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/turf_buffer_manager.sv
// Trigger-to-buffer allocator with holdoff, hold tracking and loss counting.
// Define TURF_BUFMGR_DEADTIME_EN to build the 32-bit deadtime counter.
module turf_buffer_manager
    import turf_event_pkg::*;
#(
    parameter string BUF_PER_EVENT  = "SINGLE",
    parameter int    HOLDOFF_CYCLES = 8
) (
    input  logic        clk125_i,
    input  logic        rst_n_i,
    input  logic        trig_i,
    input  logic [3:0]  trig_source_i,
    input  logic        release_i,
    input  logic [1:0]  release_buffer_i,
    input  logic        clr_all_i,
    output logic        digitize_o,
    output logic [1:0]  digitize_buffer_o,
    output logic [3:0]  digitize_source_o,
    output logic [3:0]  buffer_status_o,
    output logic [3:0]  hold_o,
    output logic        dead_o,
    output logic [15:0] trig_lost_o,
    output logic        release_error_o,
    output logic [31:0] deadtime_o
);

    localparam logic DBL = (BUF_PER_EVENT == "DOUBLE");
    localparam int   HOLD = (HOLDOFF_CYCLES < MIN_HOLDOFF) ? MIN_HOLDOFF :
                            (HOLDOFF_CYCLES > 255) ? 255 : HOLDOFF_CYCLES;
    localparam logic [7:0] CNT_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] CNT_DIG2 = 8'(HOLD - 2);

    bufmgr_state_t r_state;
    bufmgr_state_t w_state_nx;

    logic [7:0]  r_cnt;
    logic [3:0]  r_hold;
    logic [1:0]  r_rr;
    logic [1:0]  r_buf;
    logic [3:0]  r_src;
    logic [3:0]  r_status;
    logic [15:0] r_lost;
    logic        r_relerr;
    logic        r_trig_d;

    logic [3:0]  w_hold_rel;
    logic        w_free;
    logic [1:0]  w_id;
    logic [3:0]  w_mask;
    logic [1:0]  w_rr;
    logic        w_alloc;
    logic        w_lose;
    logic        w_trig_rise;

    // Releases land before allocation so a freed buffer is reusable at once.
    always_comb begin
        w_hold_rel = r_hold;
        if (release_i) w_hold_rel[release_buffer_i] = 1'b0;
    end

    assign w_trig_rise = trig_i & ~r_trig_d;

    turf_buf_allocator u_alloc (
        .i_double (DBL),
        .i_hold   (w_hold_rel),
        .i_rr     (r_rr),
        .o_free   (w_free),
        .o_id     (w_id),
        .o_mask   (w_mask),
        .o_rr     (w_rr)
    );

    always_ff @(posedge clk125_i or negedge rst_n_i) begin
        if (!rst_n_i)       r_state <= ST_IDLE;
        else if (clr_all_i) r_state <= ST_IDLE;
        else                r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_alloc    = 1'b0;
        w_lose     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (trig_i) begin
                    if (w_free) begin
                        w_alloc    = 1'b1;
                        w_state_nx = ST_DIGITIZE;
                    end else begin
                        w_lose     = 1'b1;
                        w_state_nx = ST_DEAD;
                    end
                end
            end
            ST_DIGITIZE: begin
                w_lose = w_trig_rise;
                if (r_cnt == CNT_DIG2) w_state_nx = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                w_lose = w_trig_rise;
                if (r_cnt == 8'd0) w_state_nx = w_free ? ST_IDLE : ST_DEAD;
            end
            ST_DEAD: begin
                // The cycle the mask frees up behaves as IDLE.
                if (w_free) begin
                    w_alloc    = trig_i;
                    w_state_nx = trig_i ? ST_DIGITIZE : ST_IDLE;
                end else begin
                    w_lose = w_trig_rise;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk125_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt    <= 8'd0;
            r_hold   <= 4'd0;
            r_rr     <= 2'd0;
            r_buf    <= 2'd0;
            r_src    <= 4'd0;
            r_status <= 4'd0;
            r_lost   <= 16'd0;
            r_relerr <= 1'b0;
            r_trig_d <= 1'b0;
        end else if (clr_all_i) begin
            r_cnt    <= 8'd0;
            r_hold   <= 4'd0;
            r_rr     <= 2'd0;
            r_buf    <= 2'd0;
            r_src    <= 4'd0;
            r_status <= 4'd0;
            r_lost   <= 16'd0;
            r_relerr <= 1'b0;
            r_trig_d <= 1'b0;
        end else begin
            r_trig_d <= trig_i;
            if (w_alloc)             r_cnt <= CNT_LOAD;
            else if (r_cnt != 8'd0)  r_cnt <= r_cnt - 8'd1;
            r_hold <= w_alloc ? w_mask : w_hold_rel;
            if (w_alloc) begin
                r_rr     <= w_rr;
                r_buf    <= w_id;
                r_src    <= trig_source_i;
                r_status <= w_mask;
            end
            if (w_lose) r_lost <= sat_inc16(r_lost);
            if (release_i && !r_hold[release_buffer_i]) r_relerr <= 1'b1;
        end
    end

    assign digitize_o        = (r_state == ST_DIGITIZE);
    assign digitize_buffer_o = r_buf;
    assign digitize_source_o = r_src;
    assign buffer_status_o   = r_status;
    assign hold_o            = r_hold;
    assign trig_lost_o       = r_lost;
    assign release_error_o   = r_relerr;
    assign dead_o = (r_state == ST_DEAD) ||
                    ((r_state == ST_IDLE) && !mask_free(r_hold, DBL));

`ifdef TURF_BUFMGR_DEADTIME_EN
    logic [31:0] r_deadtime;

    always_ff @(posedge clk125_i or negedge rst_n_i) begin
        if (!rst_n_i)       r_deadtime <= 32'd0;
        else if (clr_all_i) r_deadtime <= 32'd0;
        else if (dead_o)    r_deadtime <= sat_inc32(r_deadtime);
    end

    assign deadtime_o = r_deadtime;
`else
    assign deadtime_o = 32'd0;
`endif

endmodule

// File: tb/tb_turf_buffer_manager.sv
// Bench for turf_buffer_manager: SINGLE and DOUBLE instances on shared stimulus.
module tb_turf_buffer_manager;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trig;
    logic [3:0] src;
    logic       rel;
    logic [1:0] rb;
    logic       clr;

    logic        s_dig, d_dig;
    logic [1:0]  s_buf, d_buf;
    logic [3:0]  s_src, d_src;
    logic [3:0]  s_stat, d_stat;
    logic [3:0]  s_hold, d_hold;
    logic        s_dead, d_dead;
    logic [15:0] s_lost, d_lost;
    logic        s_relerr, d_relerr;
    logic [31:0] s_dt, d_dt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    turf_buffer_manager #(.BUF_PER_EVENT("SINGLE"), .HOLDOFF_CYCLES(H)) dut_s (
        .clk125_i(clk), .rst_n_i(rst_n), .trig_i(trig), .trig_source_i(src),
        .release_i(rel), .release_buffer_i(rb), .clr_all_i(clr),
        .digitize_o(s_dig), .digitize_buffer_o(s_buf), .digitize_source_o(s_src),
        .buffer_status_o(s_stat), .hold_o(s_hold), .dead_o(s_dead),
        .trig_lost_o(s_lost), .release_error_o(s_relerr), .deadtime_o(s_dt)
    );

    turf_buffer_manager #(.BUF_PER_EVENT("DOUBLE"), .HOLDOFF_CYCLES(H)) dut_d (
        .clk125_i(clk), .rst_n_i(rst_n), .trig_i(trig), .trig_source_i(src),
        .release_i(rel), .release_buffer_i(rb), .clr_all_i(clr),
        .digitize_o(d_dig), .digitize_buffer_o(d_buf), .digitize_source_o(d_src),
        .buffer_status_o(d_stat), .hold_o(d_hold), .dead_o(d_dead),
        .trig_lost_o(d_lost), .release_error_o(d_relerr), .deadtime_o(d_dt)
    );

    // Reference model: index 0 = SINGLE, 1 = DOUBLE.
    int         m_cool[2];
    bit         m_dead[2];
    logic [3:0] m_hold[2];
    logic [3:0] m_src[2];
    logic [3:0] m_stat[2];
    logic [1:0] m_rr[2];
    logic [1:0] m_buf[2];
    int         m_lost[2];
    bit         m_relerr[2];
    longint     m_dt[2];
    bit         m_prev;

    function automatic bit m_free(input logic [3:0] h, input int d);
        if (d != 0) return (h[1:0] == 2'b00) || (h[3:2] == 2'b00);
        return h != 4'hF;
    endfunction

    function automatic bit m_dead_o(input int d);
        return (m_cool[d] == 0) && (m_dead[d] || !m_free(m_hold[d], d));
    endfunction

    function automatic logic [64:0] exp_pack(input int d);
        logic [31:0] dt;
`ifdef TURF_BUFMGR_DEADTIME_EN
        dt = 32'(m_dt[d]);
`else
        dt = 32'd0;
`endif
        return {m_cool[d] >= H - 1, m_buf[d], m_src[d], m_stat[d], m_hold[d],
                m_dead_o(d), 16'(m_lost[d]), m_relerr[d], dt};
    endfunction

    function automatic logic [64:0] act_pack(input int d);
        if (d == 0)
            return {s_dig, s_buf, s_src, s_stat, s_hold, s_dead, s_lost, s_relerr, s_dt};
        return {d_dig, d_buf, d_src, d_stat, d_hold, d_dead, d_lost, d_relerr, d_dt};
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            m_cool[d] = 0; m_dead[d] = 0; m_hold[d] = 0; m_src[d] = 0;
            m_stat[d] = 0; m_rr[d] = 0; m_buf[d] = 0; m_lost[d] = 0;
            m_relerr[d] = 0; m_dt[d] = 0;
        end
        m_prev = 0;
    endtask

    task automatic model_edge();
        bit rise, fr, acc, lose, done;
        logic [3:0] post;
        logic [1:0] idx;
        bit p;
        if (!rst_n || clr) begin
            m_reset();
            return;
        end
        rise = trig && !m_prev;
        for (int d = 0; d < 2; d++) begin
            if (m_dead_o(d) && m_dt[d] < 64'hFFFF_FFFF) m_dt[d]++;
            post = m_hold[d];
            if (rel) begin
                if (!post[rb]) m_relerr[d] = 1'b1;
                post[rb] = 1'b0;
            end
            fr = m_free(post, d);
            acc = 0;
            lose = 0;
            if (m_cool[d] > 0) begin
                lose = rise;
                m_cool[d]--;
                if (m_cool[d] == 0) m_dead[d] = !fr;
            end else if (m_dead[d]) begin
                if (fr) begin
                    if (trig) acc = 1; else m_dead[d] = 0;
                end else begin
                    lose = rise;
                end
            end else if (trig) begin
                if (fr) acc = 1;
                else begin lose = 1; m_dead[d] = 1; end
            end
            if (acc) begin
                done = 0;
                if (d == 0) begin
                    for (int k = 0; k < 4; k++) begin
                        idx = m_rr[d] + 2'(k);
                        if (!done && !post[idx]) begin
                            done = 1; m_buf[d] = idx; post[idx] = 1'b1;
                            m_rr[d] = idx + 2'd1;
                        end
                    end
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        p = m_rr[d][0] ^ k[0];
                        if (!done && post[2*p] == 1'b0 && post[2*p+1] == 1'b0) begin
                            done = 1; m_buf[d] = {1'b0, p};
                            post[2*p] = 1'b1; post[2*p+1] = 1'b1;
                            m_rr[d][0] = ~p;
                        end
                    end
                end
                m_src[d] = src;
                m_stat[d] = post;
                m_cool[d] = H;
                m_dead[d] = 0;
            end
            m_hold[d] = post;
            if (lose && m_lost[d] < 65535) m_lost[d]++;
        end
        m_prev = trig;
    endtask

    task automatic step(input bit t, input logic [3:0] s, input bit r,
                        input logic [1:0] b, input bit c);
        trig = t; src = s; rel = r; rb = b; clr = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 0, 2'd0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; trig = 0; src = 0; rel = 0; rb = 0; clr = 0;
        m_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (act_pack(d) !== 65'd0) begin
                n_err++;
                $display("FAIL reset_outs[%0d]: got %h want 0", d, act_pack(d));
            end
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single_fill();
        logic [3:0] want_stat;
        want_stat = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step(1, 4'(i + 1), 0, 2'd0, 0);
            want_stat[i] = 1'b1;
            n_vec++;
            if (s_dig !== 1'b1 || s_buf !== 2'(i) || s_stat !== want_stat) begin
                n_err++;
                $display("FAIL fill%0d: dig=%b buf=%0d stat=%b want 1/%0d/%b",
                         i, s_dig, s_buf, s_stat, i, want_stat);
            end
            idle(9);
        end
        n_vec++;
        if (s_dead !== 1'b1) begin
            n_err++;
            $display("FAIL fill_dead: got %b want 1", s_dead);
        end
        step(1, 4'd5, 0, 2'd0, 0);
        step(0, 4'd0, 0, 2'd0, 0);
        n_vec++;
        if (s_lost !== 16'd1 || s_dig !== 1'b0) begin
            n_err++;
            $display("FAIL fill_lost: lost=%0d dig=%b want 1/0", s_lost, s_dig);
        end
    endtask

    task automatic test_release_same_cycle();
        step(1, 4'hA, 1, 2'd2, 0);
        n_vec++;
        if (s_dig !== 1'b1 || s_buf !== 2'd2 || s_dead !== 1'b0 ||
            s_stat !== 4'hF || s_src !== 4'hA) begin
            n_err++;
            $display("FAIL rel_alloc: dig=%b buf=%0d dead=%b stat=%b src=%h want 1/2/0/1111/a",
                     s_dig, s_buf, s_dead, s_stat, s_src);
        end
        idle(10);
    endtask

    task automatic test_lost_spacing();
        int ndig;
        step(0, 4'd0, 0, 2'd0, 1);
        ndig = 0;
        step(1, 4'd3, 0, 2'd0, 0); ndig += int'(s_dig);
        step(0, 4'd0, 0, 2'd0, 0); ndig += int'(s_dig);
        step(0, 4'd0, 0, 2'd0, 0); ndig += int'(s_dig);
        step(1, 4'd5, 0, 2'd0, 0); ndig += int'(s_dig);
        for (int i = 0; i < 8; i++) begin
            step(0, 4'd0, 0, 2'd0, 0); ndig += int'(s_dig);
        end
        n_vec++;
        if (ndig != 2 || s_lost !== 16'd1 || s_src !== 4'd3) begin
            n_err++;
            $display("FAIL spacing: dig_cycles=%0d lost=%0d src=%0d want 2/1/3",
                     ndig, s_lost, s_src);
        end
    endtask

    task automatic test_double();
        step(0, 4'd0, 0, 2'd0, 1);
        step(1, 4'd1, 0, 2'd0, 0);
        n_vec++;
        if (d_dig !== 1'b1 || d_buf !== 2'd0 || d_hold !== 4'b0011) begin
            n_err++;
            $display("FAIL dbl_first: dig=%b buf=%0d hold=%b want 1/0/0011", d_dig, d_buf, d_hold);
        end
        idle(9);
        step(1, 4'd2, 0, 2'd0, 0);
        n_vec++;
        if (d_buf !== 2'd1 || d_hold !== 4'b1111 || d_stat !== 4'b1111) begin
            n_err++;
            $display("FAIL dbl_second: buf=%0d hold=%b stat=%b want 1/1111/1111", d_buf, d_hold, d_stat);
        end
        idle(9);
        step(0, 4'd0, 1, 2'd0, 0);
        n_vec++;
        if (d_dead !== 1'b1 || d_hold !== 4'b1110) begin
            n_err++;
            $display("FAIL dbl_rel0: dead=%b hold=%b want 1/1110", d_dead, d_hold);
        end
        step(0, 4'd0, 1, 2'd1, 0);
        n_vec++;
        if (d_dead !== 1'b0 || d_hold !== 4'b1100) begin
            n_err++;
            $display("FAIL dbl_rel1: dead=%b hold=%b want 0/1100", d_dead, d_hold);
        end
        step(1, 4'd3, 0, 2'd0, 0);
        n_vec++;
        if (d_dig !== 1'b1 || d_buf !== 2'd0 || d_hold !== 4'b1111 || d_relerr !== 1'b0) begin
            n_err++;
            $display("FAIL dbl_third: dig=%b buf=%0d hold=%b err=%b want 1/0/1111/0",
                     d_dig, d_buf, d_hold, d_relerr);
        end
        idle(10);
    endtask

    task automatic test_release_error_async_reset();
        step(0, 4'd0, 0, 2'd0, 1);
        step(0, 4'd0, 1, 2'd3, 0);
        idle(3);
        n_vec++;
        if (s_relerr !== 1'b1 || d_relerr !== 1'b1) begin
            n_err++;
            $display("FAIL relerr_sticky: s=%b d=%b want 1/1", s_relerr, d_relerr);
        end
        step(0, 4'd0, 0, 2'd0, 1);
        n_vec++;
        if (s_relerr !== 1'b0) begin
            n_err++;
            $display("FAIL relerr_clr: got %b want 0", s_relerr);
        end
        step(1, 4'd7, 0, 2'd0, 0);
        n_vec++;
        if (s_dig !== 1'b1 || d_dig !== 1'b1) begin
            n_err++;
            $display("FAIL pre_async: s=%b d=%b want 1/1", s_dig, d_dig);
        end
        #1 rst_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (act_pack(d) !== 65'd0) begin
                n_err++;
                $display("FAIL async_reset[%0d]: got %h want 0", d, act_pack(d));
            end
        end
        trig = 0;
        m_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_deadtime();
        logic [31:0] want;
`ifdef TURF_BUFMGR_DEADTIME_EN
        want = 32'd100;
`else
        want = 32'd0;
`endif
        step(0, 4'd0, 0, 2'd0, 1);
        for (int s = 0; s <= 138; s++)
            step((s % 10 == 0) && (s < 40), 4'd9, 0, 2'd0, 0);
        n_vec++;
        if (s_dt !== want || s_dead !== 1'b1) begin
            n_err++;
            $display("FAIL deadtime: got %0d dead=%b want %0d/1", s_dt, s_dead, want);
        end
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (act_pack(d) !== exp_pack(d)) begin
                n_err++;
                $display("FAIL deadtime_model[%0d]: got %h want %h", d, act_pack(d), exp_pack(d));
            end
        end
    endtask

    task automatic test_random();
        bit t, r, c;
        step(0, 4'd0, 0, 2'd0, 1);
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 299) == 0);
            step(t, 4'($urandom), r, 2'($urandom), c);
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (act_pack(d) !== exp_pack(d)) begin
                    n_err++;
                    $display("FAIL random[%0d] cyc %0d: got %h want %h",
                             d, i, act_pack(d), exp_pack(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_release_same_cycle();
        test_lost_spacing();
        test_double();
        test_release_error_async_reset();
        test_deadtime();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/turf_buffer_manager.md
Name: turf_buffer_manager

Overview:
- Upstream of the event generator, in the clk125 domain.
- Accepts L3 trigger pulses and allocates a free SURF digitizer buffer (or a buffer pair) to each one.
- Issues the digitize strobe with buffer ID, source and hold snapshot.
- Tracks which buffers are held until readout releases them. Counts lost triggers and deadtime.

Parameters:
- BUF_PER_EVENT, "SINGLE": "SINGLE" allocates one buffer per trigger; "DOUBLE" allocates pair A/B (0,1) or C/D (2,3).
- HOLDOFF_CYCLES, 8: clk125 cycles from digitize assertion before the next trigger may be accepted. Legal range 8..255. At least 8 is required so the downstream 7-word FIFO write completes.

Ports:
- clk125_i  in  1  125 MHz clock
- rst_n_i  in  1  asynchronous active-low reset
- trig_i  in  1  trigger request, level-sampled each cycle
- trig_source_i  in  4  trigger source code, sampled with trig_i
- release_i  in  1  one-cycle strobe: readout finished with a buffer
- release_buffer_i  in  2  buffer being released
- clr_all_i  in  1  synchronous clear of all holds and counters
- digitize_o  out  1  digitize strobe, high exactly 2 cycles
- digitize_buffer_o  out  2  allocated buffer (SINGLE) or pair select in bit 0 (DOUBLE); stable until next digitize
- digitize_source_o  out  4  latched trig_source_i
- buffer_status_o  out  4  hold mask snapshot after allocation; stable until next digitize
- hold_o  out  4  live hold mask
- dead_o  out  1  high when no allocation is possible
- trig_lost_o  out  16  saturating count of rejected triggers
- release_error_o  out  1  sticky: release of a buffer not held
- deadtime_o  out  32  deadtime cycle count (optional feature)

Behaviour:
- Reset (async, rst_n_i low): all outputs 0; state IDLE; rr_ptr=0.
- clr_all_i: same effect as reset, but synchronous. It overrides every other input in that cycle.
- Release handling:
  - release_i clears hold[release_buffer_i] in the same clock edge.
  - If that hold bit was already 0, release_error_o is set (sticky).
  - A release in the same cycle as an allocation applies first: the allocator sees the post-release mask.
- Free test:
  - SINGLE: any hold bit is 0.
  - DOUBLE: either pair has both bits 0.
- Allocation (SINGLE):
  - Round-robin search starting at rr_ptr; first free buffer wins.
  - rr_ptr <= chosen+1 (mod 4).
- Allocation (DOUBLE):
  - Pair search starts at pair rr_ptr[0]; first fully-free pair wins.
  - digitize_buffer_o = {1'b0, pair}; both hold bits set.
  - rr_ptr[0] toggles past the chosen pair.
- FSM states: IDLE, DIGITIZE, HOLDOFF, DEAD.
  - IDLE, trig_i high and free: latch buffer, source and hold mask (including the new bits); set hold; go DIGITIZE.
  - IDLE, trig_i high and not free: trig_lost_o++; go DEAD.
  - DIGITIZE: digitize_o=1 for 2 cycles; a holdoff counter loaded with HOLDOFF_CYCLES-1 counts down; go HOLDOFF.
  - HOLDOFF: digitize_o=0. When the counter reaches 0, go DEAD if not free, else IDLE.
  - DEAD: dead_o=1. Go IDLE on the first cycle free becomes true.
- Trigger acceptance:
  - Triggers are accepted only in IDLE. A trig_i high cycle in any other state increments trig_lost_o, once per rising edge of trig_i.
  - trig_lost_o saturates at 0xFFFF.
- dead_o is combinational on registered state: (state==DEAD) or (state==IDLE and not free).
- Latency: trig_i sampled at edge N → digitize_o high at edges N+1 and N+2.
- Minimum trigger spacing: HOLDOFF_CYCLES+1 cycles.

Optional Feature:
- Macro TURF_BUFMGR_DEADTIME_EN.
- Defined: deadtime_o counts clk125 cycles with dead_o high. It is 32-bit, saturates at 0xFFFFFFFF, and is cleared by reset and by clr_all_i.
- Undefined: deadtime_o tied to 0 and the counter is not synthesized.

Decomposition:
- Shared package turf_event_pkg holds:
  - FSM state encoding
  - buffer-ID constants BUF_A..BUF_D
  - constant MIN_HOLDOFF=8
  - saturating-increment function
- One sub-module: turf_buf_allocator. It is combinational and takes the post-release hold mask, rr_ptr and mode, and returns free, the chosen ID and the next mask.

Test Plan:
- SINGLE: 4 triggers spaced 10 cycles, no releases → digitize_buffer_o 0,1,2,3. buffer_status_o 0001,0011,0111,1111. dead_o high after the 4th holdoff. A 5th trigger gives trig_lost_o=1.
- SINGLE: holds=1111, release_i with buffer 2, trigger the same cycle → digitize_buffer_o=2 on the next edge; dead_o drops.
- Trigger pulses 3 cycles apart with HOLDOFF_CYCLES=8 → the first is accepted, the second is lost (trig_lost_o=1), digitize_o high exactly 2 cycles.
- DOUBLE: two triggers → pair 0 (hold 0011) then pair 1 (hold 1111). Release buffer 0 only → still dead. Release buffer 1 → next trigger gets pair 0.
- release_buffer_i=3 while hold[3]=0 → release_error_o=1, sticky until clr_all_i. Async rst_n_i mid-DIGITIZE → digitize_o drops immediately; all outputs 0.
- With TURF_BUFMGR_DEADTIME_EN, dead for 100 cycles → deadtime_o=100. Without the macro → deadtime_o=0.
